key_state_sequencer: RTL and testbench
======================================

Name: key_state_sequencer

Overview:
- Parametrised successor to the single-key 2-bit state stepper.
- Takes one raw, active-low, asynchronous push-button input and synchronises and debounces it.
- Each debounced press steps an N-state sequencer up or down, with either wrap-around or saturating limits.
- Sits between a board key pin and mode-select logic; `state_out` drives downstream mux/LED selects.

Parameters:
- NUM_STATES, 4, number of sequencer states; legal range 2..2**STATE_W.
- STATE_W, 2, width of `state_out`.
- INIT_STATE, 0, reset and long-press state; must be < NUM_STATES.
- DEBOUNCE_CYCLES, 2, consecutive stable cycles needed to accept a level change; must be >= 1.
- WRAP, 1, 1 = wrap at the limits, 0 = saturate at the limits.
- LONG_CYCLES, 50, debounced-low cycles that make a long press (used only with the macro).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- key_in  in  1  raw key, active-low (0 = pressed), asynchronous.
- dir  in  1  step direction: 0 = up, 1 = down; synchronous, sampled on the press edge.
- state_out  out  STATE_W  current state.
- press_pulse  out  1  one-cycle pulse per accepted press.
- limit_pulse  out  1  one-cycle pulse when a press hits a limit (wraps or saturates).
- long_pulse  out  1  one-cycle pulse on long-press detection; tied to 0 without the macro.

Behaviour:
- Reset (rst=1 at an edge): all registers reset, overriding everything including a press in progress.
  - state_out = INIT_STATE.
  - press_pulse, limit_pulse and long_pulse = 0.
  - Sync flops sync1 and sync2 = 1; debounced level key_db = 1; debounce count = 0; long count = 0.
- Synchroniser: two flops, key_in -> sync1 -> sync2.
- Debounce, evaluated each edge:
  - If sync2 == key_db: count <= 0.
  - Else if count == DEBOUNCE_CYCLES-1: key_db <= sync2 and count <= 0.
  - Else: count <= count+1.
- Press event: the same edge at which key_db goes 1 -> 0.
- Latency: the edge that first samples key_in low is edge 1. key_db falls, press_pulse rises and state_out updates on edge DEBOUNCE_CYCLES+2. Release follows the same rule with no action.
- Glitch filtering: a low glitch shorter than DEBOUNCE_CYCLES cycles at sync2 produces no press and resets the count.
- Step on a press:
  - dir=0: if state == NUM_STATES-1, go to 0 when WRAP=1 or hold when WRAP=0, and assert limit_pulse; otherwise state+1.
  - dir=1: if state == 0, go to NUM_STATES-1 when WRAP=1 or hold when WRAP=0, and assert limit_pulse; otherwise state-1.
- Pulses: every pulse is high for exactly one cycle. There is no further press until key_db has returned to 1 and fallen again.
- Key held through reset: after rst deasserts, key_db=1 and sync2=0, so a held key counts as a fresh press at edge DEBOUNCE_CYCLES+2 after reset release.
- Parameter checks: an illegal parameter combination triggers a simulation $error at elaboration time.

Optional Feature:
- Macro: KEY_SEQ_LONG_PRESS_EN.
- With the macro: a long counter increments on each edge while key_db=0, saturating at LONG_CYCLES.
  - On the edge it reaches LONG_CYCLES: state_out <= INIT_STATE and long_pulse = 1 for one cycle.
  - The counter clears when key_db=1 or on rst.
  - The short press already taken at the start of the hold still counts.
- Without the macro: no long counter is built and long_pulse is constant 0.

Decomposition:
- Package key_seq_pkg:
  - DIR_UP = 1'b0 and DIR_DOWN = 1'b1.
  - KEY_PRESSED = 1'b0 and KEY_RELEASED = 1'b1.
  - A function computing the debounce counter width, $clog2(DEBOUNCE_CYCLES+1).
- Sub-module key_debounce (parameter DEBOUNCE_CYCLES): inputs clk, rst, key_in; outputs key_db and fall_evt.
  - fall_evt is combinational, high in the cycle before key_db registers 0.
  - Reused for future multi-key blocks.

Test Plan:
- Default params; rst held 5 cycles, then key_in low for 1 cycle, five times at 5-cycle spacing -> state_out stays 0 and no pulses (glitches filtered).
- Default params, dir=0; key_in low for 4 cycles, five times with 4-cycle gaps:
  - press_pulse rises on edge 4 of each press.
  - state_out goes 1,2,3,0,1.
  - limit_pulse on the 3->0 step.
- WRAP=0, dir=1 from state 0; two valid presses -> state holds 0 with limit_pulse on each press. Then dir=0 with two presses -> state 1, then 2.
- NUM_STATES=5, STATE_W=3, INIT_STATE=2; six up-presses -> state_out goes 3,4,0,1,2,3.
- Key held low across a 3-cycle rst pulse mid-sequence at state 2:
  - state_out = 0 on the first reset edge.
  - After reset release, press_pulse fires at edge 4 and state_out = 1.
- With KEY_SEQ_LONG_PRESS_EN and LONG_CYCLES=10, starting at state 0; key held low for 20 cycles:
  - press at edge 4 gives state 1.
  - long_pulse 10 cycles after key_db fell, and state_out = 0.
  - No second long_pulse until release.

Source files
------------

// File: rtl/key_seq_pkg.sv
// key_seq_pkg
// Shared constants and helpers for the key state sequencer and its debouncer.
//   DIR_UP / DIR_DOWN         : encoding of the step-direction input.
//   KEY_PRESSED / KEY_RELEASED: levels of the active-low key.
//   db_cnt_w()                : width of a counter that must hold 0..cycles.
package key_seq_pkg;

  localparam logic DIR_UP       = 1'b0;
  localparam logic DIR_DOWN     = 1'b1;
  localparam logic KEY_PRESSED  = 1'b0;
  localparam logic KEY_RELEASED = 1'b1;

  // Counter width able to represent 0..cycles; never narrower than one bit.
  function automatic int db_cnt_w(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce
// Two-flop synchroniser followed by a stable-count debouncer for one
// active-low key. A level change at the synchroniser output is accepted only
// after it has persisted for DEBOUNCE_CYCLES consecutive edges; any return to
// the accepted level restarts the count.
// Ports:
//   clk      in  clock, rising edge
//   rst      in  synchronous reset, active-high
//   key_in   in  raw asynchronous key, active-low
//   key_db   out debounced key level (1 = released)
//   fall_evt out combinational; high in the cycle before key_db registers 0
module key_debounce
  import key_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_db,
  output logic fall_evt
);

  localparam int CNT_W = db_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_param_err
    $error("key_debounce: DEBOUNCE_CYCLES must be >= 1");
  end

  logic             sync1_reg;
  logic             sync2_reg;
  logic             key_db_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             accept;

  // The synchronised level differs from the accepted one and has done so for
  // long enough: this edge commits the new level.
  assign accept   = (sync2_reg != key_db_reg) && (cnt_reg == CNT_LAST);
  assign fall_evt = accept && (sync2_reg == KEY_PRESSED);
  assign key_db   = key_db_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg  <= KEY_RELEASED;
      sync2_reg  <= KEY_RELEASED;
      key_db_reg <= KEY_RELEASED;
      cnt_reg    <= '0;
    end else begin
      sync1_reg <= key_in;
      sync2_reg <= sync1_reg;
      if (sync2_reg == key_db_reg) begin
        cnt_reg <= '0;
      end else if (accept) begin
        key_db_reg <= sync2_reg;
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/key_state_sequencer.sv
// key_state_sequencer
// Debounces one active-low push-button and steps an N-state sequencer on each
// accepted press, up or down by `dir`, wrapping or saturating at the limits.
// Optional feature macro: KEY_SEQ_LONG_PRESS_EN -- a long hold returns the
// sequencer to INIT_STATE and pulses long_pulse; without it long_pulse is 0.
// Ports:
//   clk         in  clock, rising edge
//   rst         in  synchronous reset, active-high
//   key_in      in  raw asynchronous key, active-low
//   dir         in  0 = step up, 1 = step down (sampled on the press edge)
//   state_out   out current state (STATE_W bits)
//   press_pulse out one-cycle pulse per accepted press
//   limit_pulse out one-cycle pulse when a press wraps or saturates
//   long_pulse  out one-cycle pulse on long-press detection
module key_state_sequencer
  import key_seq_pkg::*;
#(
  parameter int NUM_STATES      = 4,
  parameter int STATE_W         = 2,
  parameter int INIT_STATE      = 0,
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int WRAP            = 1,
  parameter int LONG_CYCLES     = 50
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_in,
  input  logic               dir,
  output logic [STATE_W-1:0] state_out,
  output logic               press_pulse,
  output logic               limit_pulse,
  output logic               long_pulse
);

  localparam logic [STATE_W-1:0] LAST_STATE = STATE_W'(NUM_STATES - 1);
  localparam logic [STATE_W-1:0] INIT_VAL   = STATE_W'(INIT_STATE);

  if ((NUM_STATES < 2) || (NUM_STATES > (1 << STATE_W)) ||
      (INIT_STATE < 0) || (INIT_STATE >= NUM_STATES) ||
      (DEBOUNCE_CYCLES < 1) || ((WRAP != 0) && (WRAP != 1)) ||
      (LONG_CYCLES < 1)) begin : g_param_err
    $error("key_state_sequencer: illegal parameter combination");
  end

  logic key_db;
  logic fall_evt;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .key_in  (key_in),
    .key_db  (key_db),
    .fall_evt(fall_evt)
  );

  logic [STATE_W-1:0] state_reg, state_next;
  logic               press_reg, press_next;
  logic               limit_reg, limit_next;

`ifdef KEY_SEQ_LONG_PRESS_EN
  localparam int LONG_W = db_cnt_w(LONG_CYCLES);
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES);

  logic [LONG_W-1:0] long_cnt_reg, long_cnt_next;
  logic              long_reg, long_next;
  logic              long_hit;

  // Counter saturates at LONG_MAX, so the hit fires once per hold.
  assign long_hit = (key_db == KEY_PRESSED) &&
                    (long_cnt_reg == LONG_W'(LONG_CYCLES - 1));

  always_comb begin
    long_cnt_next = long_cnt_reg;
    if (key_db == KEY_RELEASED) begin
      long_cnt_next = '0;
    end else if (long_cnt_reg != LONG_MAX) begin
      long_cnt_next = long_cnt_reg + LONG_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      long_cnt_reg <= '0;
      long_reg     <= 1'b0;
    end else begin
      long_cnt_reg <= long_cnt_next;
      long_reg     <= long_next;
    end
  end

  assign long_pulse = long_reg;
`else
  // The debounced level only feeds the long-press counter.
  logic key_db_unused;
  assign key_db_unused = key_db;
  assign long_pulse    = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    press_next = 1'b0;
    limit_next = 1'b0;
`ifdef KEY_SEQ_LONG_PRESS_EN
    long_next  = 1'b0;
`endif
    if (fall_evt) begin
      press_next = 1'b1;
      if (dir == DIR_UP) begin
        if (state_reg == LAST_STATE) begin
          limit_next = 1'b1;
          state_next = (WRAP != 0) ? '0 : state_reg;
        end else begin
          state_next = state_reg + STATE_W'(1);
        end
      end else begin
        if (state_reg == '0) begin
          limit_next = 1'b1;
          state_next = (WRAP != 0) ? LAST_STATE : state_reg;
        end else begin
          state_next = state_reg - STATE_W'(1);
        end
      end
    end
`ifdef KEY_SEQ_LONG_PRESS_EN
    // A press needs key_db=1 and a long hit needs key_db=0, so they never
    // coincide; the long hit simply overrides.
    if (long_hit) begin
      state_next = INIT_VAL;
      long_next  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= INIT_VAL;
      press_reg <= 1'b0;
      limit_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      press_reg <= press_next;
      limit_reg <= limit_next;
    end
  end

  assign state_out   = state_reg;
  assign press_pulse = press_reg;
  assign limit_pulse = limit_reg;

endmodule

// File: tb/tb_key_state_sequencer.sv
// Scoreboard bench: three sequencer instances share one key/dir/reset stream
// (default, saturating, and 5-state with INIT_STATE=2). Every driven press
// pushes the expected state/limit per instance; monitors pop on press_pulse.
module tb_key_state_sequencer;

  typedef struct {
    int st;
    int lim;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key = 1'b1;
  logic       dir = 1'b0;
  logic [1:0] st0, st1;
  logic [2:0] st2;
  logic       pp0, pp1, pp2;
  logic       lp0, lp1, lp2;
  logic       lg0, lg1, lg2;

  int n_checks = 0;
  int n_errors = 0;

  exp_t press_q[3][$];
  int   long_q[3][$];
  int   mstate[3];
  int   prev_pp[3];
  int   prev_lg[3];

  localparam int N_ST[3]  = '{4, 4, 5};
  localparam int WRP[3]   = '{1, 0, 1};
  localparam int INIT[3]  = '{0, 0, 2};

  always #5 clk = ~clk;

  key_state_sequencer #(.LONG_CYCLES(10)) dut0 (
    .clk(clk), .rst(rst), .key_in(key), .dir(dir), .state_out(st0),
    .press_pulse(pp0), .limit_pulse(lp0), .long_pulse(lg0)
  );
  key_state_sequencer #(.WRAP(0), .LONG_CYCLES(10)) dut1 (
    .clk(clk), .rst(rst), .key_in(key), .dir(dir), .state_out(st1),
    .press_pulse(pp1), .limit_pulse(lp1), .long_pulse(lg1)
  );
  key_state_sequencer #(.NUM_STATES(5), .STATE_W(3), .INIT_STATE(2),
                        .LONG_CYCLES(10)) dut2 (
    .clk(clk), .rst(rst), .key_in(key), .dir(dir), .state_out(st2),
    .press_pulse(pp2), .limit_pulse(lp2), .long_pulse(lg2)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Spec-level step rule for one press.
  task automatic push_press(input bit d);
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.lim = 0;
      if (d == 1'b0) begin
        if (mstate[i] == N_ST[i] - 1) begin
          e.lim = 1;
          e.st  = WRP[i] ? 0 : mstate[i];
        end else e.st = mstate[i] + 1;
      end else begin
        if (mstate[i] == 0) begin
          e.lim = 1;
          e.st  = WRP[i] ? N_ST[i] - 1 : 0;
        end else e.st = mstate[i] - 1;
      end
      mstate[i] = e.st;
      press_q[i].push_back(e);
    end
  endtask

  task automatic push_long();
    for (int i = 0; i < 3; i++) begin
      long_q[i].push_back(INIT[i]);
      mstate[i] = INIT[i];
    end
  endtask

  task automatic mon(input int d, input int st, input logic pp, input logic lp,
                     input logic lg);
    if (pp) begin
      check_val($sformatf("press_width%0d", d), prev_pp[d], 0);
      if (press_q[d].size() == 0) begin
        check_val($sformatf("press_unexp%0d", d), int'(pp), 0);
      end else begin
        exp_t e = press_q[d].pop_front();
        check_val($sformatf("state%0d", d), st, e.st);
        check_val($sformatf("limit%0d", d), int'(lp), e.lim);
      end
    end else if (lp) begin
      check_val($sformatf("limit_no_press%0d", d), int'(lp), 0);
    end
    if (lg) begin
      check_val($sformatf("long_width%0d", d), prev_lg[d], 0);
      if (long_q[d].size() == 0) begin
        check_val($sformatf("long_unexp%0d", d), int'(lg), 0);
      end else begin
        int e = long_q[d].pop_front();
        check_val($sformatf("long_state%0d", d), st, e);
      end
    end
    prev_pp[d] = int'(pp);
    prev_lg[d] = int'(lg);
  endtask

  always @(negedge clk) begin
    mon(0, int'(st0), pp0, lp0, lg0);
    mon(1, int'(st1), pp1, lp1, lg1);
    mon(2, int'(st2), pp2, lp2, lg2);
  end

  task automatic check_states(input string tag);
    check_val({tag, "_0"}, int'(st0), mstate[0]);
    check_val({tag, "_1"}, int'(st1), mstate[1]);
    check_val({tag, "_2"}, int'(st2), mstate[2]);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) mstate[i] = INIT[i];
  endtask

  // Key low for `low` edges; reports press/long edge numbers seen on dut0.
  task automatic press(input bit d, input int low, input int gap,
                       output int lat, output int long_edge, output int n_long);
    @(negedge clk);
    dir = d;
    push_press(d);
    key = 1'b0;
    lat = 0;
    long_edge = 0;
    n_long = 0;
    for (int i = 1; i <= low; i++) begin
      @(posedge clk);
      #1;
      if (pp0 && lat == 0) lat = i;
      if (lg0) begin
        n_long++;
        if (long_edge == 0) long_edge = i;
      end
    end
    @(negedge clk);
    key = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    int lat, le, nl;
    for (int i = 0; i < 3; i++) begin
      mstate[i] = INIT[i];
      prev_pp[i] = 0;
      prev_lg[i] = 0;
    end
    // Reset state
    repeat (5) @(negedge clk);
    check_states("reset");
    check_val("reset_press", int'(pp0), 0);
    check_val("reset_limit", int'(lp0), 0);
    check_val("reset_long", int'(lg0), 0);
    rst = 1'b0;

    // Single-cycle glitches must be filtered
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      key = 1'b0;
      @(negedge clk);
      key = 1'b1;
      repeat (3) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check_states("glitch");

    // Five up-presses
    for (int p = 0; p < 5; p++) begin
      press(1'b0, 4, 4, lat, le, nl);
      check_val("press_lat_up", lat, 4);
    end
    check_states("after_up5");

    // Down from 0 (saturating instance holds), then up twice
    do_reset(2);
    for (int p = 0; p < 2; p++) press(1'b1, 4, 4, lat, le, nl);
    check_states("after_down2");
    for (int p = 0; p < 2; p++) press(1'b0, 4, 4, lat, le, nl);
    check_states("after_up2");

    // Six up-presses from reset (dut0 ends at state 2)
    do_reset(2);
    for (int p = 0; p < 6; p++) press(1'b0, 4, 4, lat, le, nl);
    check_states("after_up6");
    check_val("st0_before_rst", int'(st0), 2);

    // Key held low across a 3-cycle reset
    @(negedge clk);
    key = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) mstate[i] = INIT[i];
    @(posedge clk);
    #1;
    check_states("rst_first_edge");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dir = 1'b0;
    push_press(1'b0);
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      if (pp0 && lat == 0) lat = i;
    end
    check_val("held_rst_lat", lat, 4);
    check_val("held_rst_state", int'(st0), 1);
    @(negedge clk);
    key = 1'b1;
    repeat (8) @(negedge clk);

    // Long hold of 20 cycles from state 0
    do_reset(2);
    @(negedge clk);
    dir = 1'b0;
    push_press(1'b0);
`ifdef KEY_SEQ_LONG_PRESS_EN
    push_long();
`endif
    key = 1'b0;
    lat = 0;
    le = 0;
    nl = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (pp0 && lat == 0) lat = i;
      if (lg0) begin
        nl++;
        if (le == 0) le = i;
      end
    end
    check_val("long_press_lat", lat, 4);
`ifdef KEY_SEQ_LONG_PRESS_EN
    check_val("long_edge", le, 14);
    check_val("long_count", nl, 1);
`else
    check_val("long_count", nl, 0);
`endif
    check_states("during_hold");
    @(negedge clk);
    key = 1'b1;
    repeat (8) @(negedge clk);
    check_states("final");

    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("press_q_left%0d", i), press_q[i].size(), 0);
      check_val($sformatf("long_q_left%0d", i), long_q[i].size(), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
